// File: rtl/lut_seq_pkg.sv
// Shared types and constants for the programmable truth-table cell.
package lut_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  // Reset truth table of the classic three-input cell (minterms 0,2,4,6).
  localparam logic [7:0] LUT_INIT_DEFAULT = 8'h55;

  // sum(0,2,4,6,7): the default function with minterm 7 added.
  localparam logic [7:0] LUT_SUM_02467 = 8'hD5;

  // The default pattern repeated so any legal depth (up to 64) can slice it.
  localparam logic [63:0] LUT_INIT_PATTERN = {8{LUT_INIT_DEFAULT}};

  // Truth-table depth for an n-input cell.
  function automatic int depth_of(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/lut_cfg_loader.sv
// Serial truth-table loader: gathers DEPTH bits into a shadow register and
// raises a one-cycle commit so the owner can swap the table atomically.
module lut_cfg_loader
  import lut_seq_pkg::*;
#(
  parameter int N_IN = 3,
  localparam int DEPTH = depth_of(N_IN),
  localparam int CW = (N_IN < 1) ? 1 : N_IN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_ready,
  output logic             commit,
  output logic             busy,
  output logic [DEPTH-1:0] shadow
);

  cfg_state_t       state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [DEPTH-1:0] shadow_next;

  // State, bit counter and shadow table registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      shadow <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      shadow <= shadow_next;
    end
  end

  // Next-state logic; a restart keeps stale shadow bits and drops a coincident bit.
  always_comb begin
    state_next  = state;
    count_next  = count;
    shadow_next = shadow;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_next = LOAD;
          count_next = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          count_next = '0;
        end else if (cfg_valid) begin
          shadow_next[count] = cfg_bit;
          if (count == CW'(DEPTH - 1)) begin
            state_next = COMMIT;
          end else begin
            count_next = count + CW'(1);
          end
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cfg_ready = (state == LOAD);
  assign commit    = (state == COMMIT);
  assign busy      = (state != IDLE);

endmodule

// File: rtl/lut_seq_cell.sv
// Programmable N-input truth-table cell with registered raw and gated outputs.
// The active table is swapped only on the loader's commit cycle, so every
// evaluation sees either the whole old table or the whole new one.
module lut_seq_cell
  import lut_seq_pkg::*;
#(
  parameter int N_IN = 3,
  parameter logic [2**N_IN-1:0] INIT = LUT_INIT_PATTERN[2**N_IN-1:0]
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_sel,
  input  logic            gate,
  output logic            out_valid,
  output logic            out_e,
  output logic            out_f,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  output logic            busy
);

  localparam int DEPTH = depth_of(N_IN);

  logic [DEPTH-1:0] active_table;
  logic [DEPTH-1:0] shadow;
  logic             commit;

  lut_cfg_loader #(
    .N_IN(N_IN)
  ) u_loader (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_bit  (cfg_bit),
    .cfg_ready(cfg_ready),
    .commit   (commit),
    .busy     (busy),
    .shadow   (shadow)
  );

  assign cfg_done = commit;

  // Active table: reverts to INIT on reset, takes the shadow on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_table <= INIT;
    end else if (commit) begin
      active_table <= shadow;
    end
  end

  // Evaluation pipeline: one result per cycle, outputs hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_e     <= 1'b0;
      out_f     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_e <= active_table[in_sel];
        out_f <= active_table[in_sel] & gate;
      end
    end
  end

endmodule

// File: tb/tb_lut_seq_cell.sv
// Directed self-checking bench for lut_seq_cell with hand-computed tables.
module tb_lut_seq_cell;
  import lut_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_sel;
  logic       gate;
  logic       out_valid;
  logic       out_e;
  logic       out_f;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_bit;
  logic       cfg_ready;
  logic       cfg_done;
  logic       busy;

  int checks;
  int failures;
  int done_count;

  lut_seq_cell #(
    .N_IN(3),
    .INIT(8'h55)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sel   (in_sel),
    .gate     (gate),
    .out_valid(out_valid),
    .out_e    (out_e),
    .out_f    (out_f),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_bit  (cfg_bit),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count commit pulses mid-cycle so each COMMIT cycle is seen exactly once.
  always @(negedge clk) begin
    if (cfg_done === 1'b1) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bits(input logic [7:0] value, input int nbits, input bit gaps);
    for (int k = 0; k < nbits; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = value[k];
      tick();
      cfg_valid = 1'b0;
      if (gaps) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({out_valid, out_e, out_f, cfg_ready, cfg_done, busy} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b want=000000",
               {out_valid, out_e, out_f, cfg_ready, cfg_done, busy});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sweep(input string name, input logic [7:0] exp_table, input logic g);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sel   = 3'(i);
      gate     = g;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_e !== exp_table[i] || out_f !== (exp_table[i] & g)) begin
        failures++;
        $display("[TB] FAIL %s sel=%0d got v/e/f=%b%b%b want=1%b%b", name, i,
                 out_valid, out_e, out_f, exp_table[i], exp_table[i] & g);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_hold();
    in_valid = 1'b0;
    in_sel   = 3'd0;
    gate     = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_e !== 1'b0 || out_f !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold got v/e/f=%b%b%b want=000", out_valid, out_e, out_f);
    end
  endtask

  task automatic test_load_switch();
    logic [7:0] v;
    int d0;
    v = LUT_SUM_02467;
    in_valid  = 1'b1;
    in_sel    = 3'd7;
    gate      = 1'b1;
    d0        = done_count;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b1 || out_e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_enter got ready/busy/e=%b%b%b want=110", cfg_ready, busy, out_e);
    end
    for (int k = 0; k < 8; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = v[k];
      tick();
      cfg_valid = 1'b0;
      if (k < 7) begin
        checks++;
        if (out_e !== 1'b0 || cfg_done !== 1'b0 || cfg_ready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL load_bit%0d got e/done/ready=%b%b%b want=001", k, out_e, cfg_done, cfg_ready);
        end
        tick();
      end
    end
    checks++;
    if (cfg_done !== 1'b1 || cfg_ready !== 1'b0 || busy !== 1'b1 || out_e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL commit_cycle got done/ready/busy/e=%b%b%b%b want=1010",
               cfg_done, cfg_ready, busy, out_e);
    end
    tick();
    checks++;
    if (out_e !== 1'b0 || cfg_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL issued_in_commit got e/done/busy=%b%b%b want=000", out_e, cfg_done, busy);
    end
    tick();
    checks++;
    if (out_e !== 1'b1 || out_f !== 1'b1) begin
      failures++;
      $display("[TB] FAIL after_commit got e/f=%b%b want=11", out_e, out_f);
    end
    in_valid = 1'b0;
    checks++;
    if (done_count - d0 !== 1) begin
      failures++;
      $display("[TB] FAIL done_pulses got=%0d want=1", done_count - d0);
    end
  endtask

  task automatic test_restart();
    int d0;
    d0        = done_count;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    load_bits(8'hFF, 5, 1'b0);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    load_bits(8'h00, 7, 1'b1);
    checks++;
    if (done_count - d0 !== 0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL restart_no_early_done got done=%0d ready=%b want done=0 ready=1",
               done_count - d0, cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_bit   = 1'b0;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL restart_commit got done=%b want=1", cfg_done);
    end
    tick();
    checks++;
    if (done_count - d0 !== 1) begin
      failures++;
      $display("[TB] FAIL restart_done_pulses got=%0d want=1", done_count - d0);
    end
  endtask

  task automatic test_reset_mid_load();
    int d0;
    d0        = done_count;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    load_bits(8'hFF, 4, 1'b0);
    in_valid = 1'b1;
    in_sel   = 3'd0;
    gate     = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_e, out_f, cfg_ready, cfg_done, busy} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL async_reset got=%b want=000000",
               {out_valid, out_e, out_f, cfg_ready, cfg_done, busy});
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    tick();
    tick();
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0 || busy !== 1'b0 || done_count - d0 !== 0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got ready=%b busy=%b done=%0d want 0 0 0",
               cfg_ready, busy, done_count - d0);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    done_count = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 3'd0;
    gate       = 1'b0;
    cfg_start  = 1'b0;
    cfg_valid  = 1'b0;
    cfg_bit    = 1'b0;

    test_reset();
    test_sweep("sweep_init_gate1", 8'h55, 1'b1);
    test_sweep("sweep_init_gate0", 8'h55, 1'b0);
    test_hold();
    test_load_switch();
    test_sweep("sweep_d5", LUT_SUM_02467, 1'b1);
    test_restart();
    test_sweep("sweep_restart_00", 8'h00, 1'b1);
    test_reset_mid_load();
    test_sweep("sweep_after_reset", 8'h55, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
